capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
//   Capture sequencer for the 5-channel logic-analyzer sample path. Counts decimated sample
//   strobes (wrt_smpl from clk_rst_smpl) and generates write enable/address for the circular
//   sample RAM fed by the sampler_reg smpl outputs. Arms the channel trigger logic once enough
//   pre-trigger history is stored, then records trig_pos post-trigger samples and flags done.
// PARAMETERS
//   ADDR_W   9   sample RAM address width; DEPTH = 2**ADDR_W entries
// PORTS
//   clk        in   1       system clock (same clk as sampler_reg / trigger logic)
//   rst        in   1       asynchronous, active-high reset
//   start      in   1       1-cycle pulse: begin a capture (honoured only in IDLE)
//   stop       in   1       abort: any state -> IDLE next cycle
//   clr_done   in   1       acknowledge: DONE -> IDLE
//   wrt_smpl   in   1       1-cycle strobe per decimated sample
//   triggered  in   1       combined channel trigger (level)
//   trig_pos   in   ADDR_W  number of samples kept after the trigger
//   we         out  1       sample RAM write enable
//   waddr      out  ADDR_W  sample RAM write address
//   set_armed  out  1       arms channel_trigger_logic
//   busy       out  1       high in PRE, ARMED, POST
//   capture_done out 1      high in DONE
//   trace_end  out  ADDR_W  address of last sample written in the completed capture
// BEHAVIOUR
//   Reset: state=IDLE, waddr=0, pre/post counters=0, trace_end=0; we/set_armed/busy/capture_done=0.
//   States: IDLE, PRE, ARMED, POST, DONE (registered). Priority each cycle: stop > clr_done > others.
//   we = wrt_smpl & (state in PRE|ARMED|POST), combinational, zero latency; waddr is a register
//     holding the current write address, incremented (mod DEPTH, wraps DEPTH-1 -> 0) on every we.
//   IDLE: start -> PRE; waddr<=0; pre_cnt<=0; trig_pos latched into trig_pos_q (held whole capture).
//   PRE: each we increments pre_cnt (ADDR_W+1 bits). When write brings pre_cnt to DEPTH - trig_pos_q
//     -> ARMED next cycle. triggered is ignored in PRE.
//   ARMED: set_armed=1 (registered state decode, rises cycle after the threshold write). Writes
//     continue circularly. triggered=1 -> POST, post_cnt<=0; a wrt_smpl in that same cycle is
//     written as a pre-trigger sample and not counted.
//   POST: set_armed=0. Each we increments post_cnt; on the write that makes post_cnt==trig_pos_q
//     -> DONE, trace_end<=address of that write. trig_pos_q==0: POST -> DONE on the first cycle
//     with no write, trace_end<=waddr-1 (mod DEPTH, last address written).
//   DONE: we=0, capture_done=1, waddr/trace_end held; start ignored; clr_done -> IDLE.
//   stop in any state -> IDLE, trace_end unchanged, we still follows wrt_smpl in the stop cycle.
//   rst mid-capture: all state/outputs return to reset values immediately (async).
//   triggered held high across ARMED entry causes trigger on first ARMED cycle (no edge detect here).
// TESTING
//   ADDR_W=4 (DEPTH=16), trig_pos=4, start, 12 strobes -> addrs 0..11 written, set_armed
//     rises cycle after 12th; 3 strobes (12,13,14), triggered, 4 strobes (15,0,1,2) ->
//     capture_done=1, trace_end=2, we=0 on further strobes.
//   trig_pos=0: 16 pre strobes then trigger -> DONE with no post writes, trace_end=last written addr.
//   triggered=1 throughout PRE -> no early arm; ARMED entered only after DEPTH-trig_pos writes,
//     then immediate POST.
//   wrt_smpl and triggered coincident in ARMED -> sample written, post_cnt stays 0, 4 more needed.
//   trig_pos=15: 1 pre strobe -> ARMED; change trig_pos mid-capture -> no effect (latched).
//   rst or stop asserted mid-POST -> IDLE, waddr=0 (rst) / held (stop), busy=0, no further we;
//     clr_done in DONE -> IDLE, new start begins at waddr=0.

Source files
------------

// File: rtl/capture_ctrl.sv
// Capture sequencer for the logic-analyzer sample RAM: fills pre-trigger history,
// arms the trigger logic, records trig_pos post-trigger samples, then reports done.
module capture_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clr_done,
    input  logic              wrt_smpl,
    input  logic              triggered,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              set_armed,
    output logic              busy,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trace_end
);

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_e;

    localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_C   = 1;
    localparam logic [ADDR_W-1:0] ONE_A   = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
    logic [ADDR_W-1:0] trace_end_q, trace_end_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_pos_q  <= '0;
            trace_end_q <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_pos_q  <= trig_pos_d;
            trace_end_q <= trace_end_d;
        end
    end

    always_comb begin
        busy         = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
        set_armed    = (state_q == ARMED);
        capture_done = (state_q == DONE);
        we           = wrt_smpl & busy;
        waddr        = waddr_q;
        trace_end    = trace_end_q;
    end

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_pos_d  = trig_pos_q;
        trace_end_d = trace_end_q;

        // The write pointer follows every accepted write, including one in an abort cycle
        if (we) begin
            waddr_d = waddr_q + ONE_A;
        end

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = PRE;
                        waddr_d    = '0;
                        pre_cnt_d  = '0;
                        trig_pos_d = trig_pos;
                    end
                end
                PRE: begin
                    if (we) begin
                        pre_cnt_d = pre_cnt_q + ONE_C;
                        if (pre_cnt_d == DEPTH_C - {1'b0, trig_pos_q}) begin
                            state_d = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (triggered) begin
                        state_d    = POST;
                        post_cnt_d = '0;
                    end
                end
                POST: begin
                    if (we) begin
                        post_cnt_d = post_cnt_q + ONE_A;
                        if ((trig_pos_q != '0) && (post_cnt_d == trig_pos_q)) begin
                            state_d     = DONE;
                            trace_end_d = waddr_q;
                        end
                    end else if (trig_pos_q == '0) begin
                        // No post-trigger samples wanted: the last pre-trigger write ends the trace
                        state_d     = DONE;
                        trace_end_d = waddr_q - ONE_A;
                    end
                end
                DONE: begin
                    if (clr_done) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl with a 16-entry RAM: expected write addresses and
// trace_end values are queued by the stimulus and popped by an independent monitor.
module tb_capture_ctrl;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk;
   logic              rst;
   logic              start;
   logic              stop;
   logic              clr_done;
   logic              wrt_smpl;
   logic              triggered;
   logic [ADDR_W-1:0] trig_pos;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic              set_armed;
   logic              busy;
   logic              capture_done;
   logic [ADDR_W-1:0] trace_end;

   int checks   = 0;
   int failures = 0;
   int expAddr  = 0;
   int writeQ[$];
   int traceQ[$];
   bit donePrev = 0;

   capture_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .clr_done     (clr_done),
      .wrt_smpl     (wrt_smpl),
      .triggered    (triggered),
      .trig_pos     (trig_pos),
      .we           (we),
      .waddr        (waddr),
      .set_armed    (set_armed),
      .busy         (busy),
      .capture_done (capture_done),
      .trace_end    (trace_end)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   function automatic void checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endfunction

   // Monitor: every write the DUT presents must match the next queued address, and every
   // completed capture must report the queued trace_end
   always @(negedge clk) begin
      if (we) begin
         if (writeQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_we: actual=write@%0d required=no write", waddr);
         end else begin
            checkOutput("waddr", int'(waddr), writeQ.pop_front());
         end
      end
      if (capture_done && !donePrev) begin
         if (traceQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: actual=done required=not done");
         end else begin
            checkOutput("trace_end", int'(trace_end), traceQ.pop_front());
         end
      end
      donePrev = capture_done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of control inputs, then everything returns low
   task automatic applyStimulus(input logic s, input logic sp, input logic c, input logic t);
      start     = s;
      stop      = sp;
      clr_done  = c;
      triggered = t;
      if (s) expAddr = 0;
      tick();
      start     = 1'b0;
      stop      = 1'b0;
      clr_done  = 1'b0;
      triggered = 1'b0;
   endtask

   task automatic strobe(input bit expectWrite);
      wrt_smpl = 1'b1;
      if (expectWrite) begin
         writeQ.push_back(expAddr);
         expAddr = (expAddr + 1) % DEPTH;
      end
      tick();
      wrt_smpl = 1'b0;
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) strobe(1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      clr_done  = 1'b0;
      wrt_smpl  = 1'b0;
      triggered = 1'b0;
      trig_pos  = 4'd4;
      tick();
      tick();

      // Reset state
      checkOutput("rst_waddr", int'(waddr), 0);
      checkOutput("rst_we", int'(we), 0);
      checkOutput("rst_set_armed", int'(set_armed), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(capture_done), 0);
      checkOutput("rst_trace_end", int'(trace_end), 0);
      rst = 1'b0;
      tick();
      strobe(1'b0);

      // Basic capture: trig_pos=4, 12 pre, 3 armed, trigger, 4 post -> trace_end 2
      trig_pos = 4'd4;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_busy", int'(busy), 1);
      strobes(11);
      checkOutput("t1_not_armed_11", int'(set_armed), 0);
      strobes(1);
      checkOutput("t1_armed_12", int'(set_armed), 1);
      strobes(3);
      traceQ.push_back(2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("t1_post_set_armed", int'(set_armed), 0);
      checkOutput("t1_post_busy", int'(busy), 1);
      strobes(4);
      checkOutput("t1_done", int'(capture_done), 1);
      checkOutput("t1_done_busy", int'(busy), 0);
      checkOutput("t1_done_waddr", int'(waddr), 3);
      strobe(1'b0);
      strobe(1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_start_ignored", int'(capture_done), 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("t1_clr_done", int'(capture_done), 0);
      checkOutput("t1_clr_busy", int'(busy), 0);

      // trig_pos=0: 16 pre writes, trigger, done with no post writes -> trace_end 15
      trig_pos = 4'd0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      strobes(15);
      checkOutput("t2_not_armed_15", int'(set_armed), 0);
      strobes(1);
      checkOutput("t2_armed", int'(set_armed), 1);
      checkOutput("t2_waddr_wrap", int'(waddr), 0);
      traceQ.push_back(15);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("t2_done", int'(capture_done), 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      // triggered held through PRE: arm only after 6 writes (trig_pos=10), then stop in POST
      trig_pos  = 4'd10;
      triggered = 1'b1;
      start     = 1'b1;
      expAddr   = 0;
      tick();
      start = 1'b0;
      strobes(5);
      checkOutput("t3_no_early_arm", int'(set_armed), 0);
      checkOutput("t3_still_busy", int'(busy), 1);
      strobes(1);
      checkOutput("t3_armed", int'(set_armed), 1);
      tick();
      checkOutput("t3_immediate_post", int'(set_armed), 0);
      checkOutput("t3_post_busy", int'(busy), 1);
      triggered = 1'b0;
      strobes(2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("t3_stop_busy", int'(busy), 0);
      checkOutput("t3_stop_waddr_held", int'(waddr), 8);
      checkOutput("t3_stop_trace_end", int'(trace_end), 15);
      strobe(1'b0);

      // Write coincident with trigger counts as pre-trigger: 4 more writes needed
      trig_pos = 4'd4;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      strobes(12);
      triggered = 1'b1;
      strobe(1'b1);
      triggered = 1'b0;
      traceQ.push_back(0);
      strobes(3);
      checkOutput("t4_not_done_3", int'(capture_done), 0);
      strobes(1);
      checkOutput("t4_done_4", int'(capture_done), 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      // trig_pos=15 latched at start: later change to 3 has no effect
      trig_pos = 4'd15;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      trig_pos = 4'd3;
      strobes(1);
      checkOutput("t5_armed_after_1", int'(set_armed), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      traceQ.push_back(15);
      strobes(3);
      checkOutput("t5_latched_not_done", int'(capture_done), 0);
      strobes(12);
      checkOutput("t5_done", int'(capture_done), 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-POST, then a fresh capture starts at address 0
      trig_pos = 4'd4;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      strobes(12);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      strobes(2);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_waddr", int'(waddr), 0);
      checkOutput("t6_rst_busy", int'(busy), 0);
      checkOutput("t6_rst_trace_end", int'(trace_end), 0);
      tick();
      rst = 1'b0;
      strobe(1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_restart_waddr", int'(waddr), 0);
      strobes(2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      strobe(1'b0);
      tick();

      checkOutput("pending_writes", writeQ.size(), 0);
      checkOutput("pending_dones", traceQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
